// File: rtl/eeprom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_pkg
// Description : Shared constants, operation type codes and controller state
//               encoding for the EEPROM transaction controller.
// Revision    : 1.0 - initial release
// ============================================================================
package eeprom_pkg;

    // Operation type codes shared with the I2C byte engine
    localparam logic [1:0] TYPE_W = 2'd1;
    localparam logic [1:0] TYPE_R = 2'd2;

    // Default parameter values
    localparam logic [6:0] DEF_DEVICE_ADDR    = 7'h50;
    localparam int         DEF_BUF_DEPTH      = 64;
    localparam int         DEF_PAGE_SIZE      = 16;
    localparam int         DEF_WR_WAIT_CYCLES = 500000;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_BUSY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/eeprom_if.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_if
// Description : User request/payload/read-back channel and engine operation
//               channel of the EEPROM controller, bundled as one interface.
//               The slave modport is the controller's view; the master
//               modport is the view of whatever drives the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface eeprom_if;
    // User side
    logic [1:0]  i_user_type;
    logic [15:0] i_user_addr;
    logic [7:0]  i_user_len;
    logic        i_user_valid;
    logic        o_user_ready;
    logic [7:0]  i_user_wdata;
    logic        i_user_wvalid;
    logic        o_user_wready;
    logic [7:0]  o_user_rdata;
    logic        o_user_rvalid;
    logic        o_user_rlast;
    logic        o_user_done;
    // Engine side
    logic [6:0]  o_operation_device;
    logic [15:0] o_operation_addr;
    logic [7:0]  o_operation_len;
    logic [1:0]  o_operation_type;
    logic        o_operation_valid;
    logic        i_operation_ready;
    logic        i_write_req;
    logic [7:0]  o_write_data;
    logic [7:0]  i_read_data;
    logic        i_read_valid;

    modport slave (
        input  i_user_type, i_user_addr, i_user_len, i_user_valid,
        input  i_user_wdata, i_user_wvalid,
        input  i_operation_ready, i_write_req, i_read_data, i_read_valid,
        output o_user_ready, o_user_wready, o_user_rdata, o_user_rvalid,
        output o_user_rlast, o_user_done,
        output o_operation_device, o_operation_addr, o_operation_len,
        output o_operation_type, o_operation_valid, o_write_data
    );

    modport master (
        output i_user_type, i_user_addr, i_user_len, i_user_valid,
        output i_user_wdata, i_user_wvalid,
        output i_operation_ready, i_write_req, i_read_data, i_read_valid,
        input  o_user_ready, o_user_wready, o_user_rdata, o_user_rvalid,
        input  o_user_rlast, o_user_done,
        input  o_operation_device, o_operation_addr, o_operation_len,
        input  o_operation_type, o_operation_valid, o_write_data
    );
endinterface
`default_nettype wire

// File: rtl/eeprom_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_wbuf
// Description : Synchronous byte FIFO holding write payload. Show-ahead
//               read port, synchronous flush, fill count output.
// Revision    : 1.0 - initial release
// ============================================================================
module eeprom_wbuf #(
    parameter int P_DEPTH = 64
) (
    input  wire               i_clk,
    input  wire               i_rst,
    input  wire               flush,
    input  wire               push,
    input  wire  [7:0]        din,
    input  wire               pop,
    output logic [7:0]        dout,
    output logic              empty,
    output logic              full,
    output logic [$clog2(P_DEPTH):0] count
);
    localparam int AW = $clog2(P_DEPTH);

    logic [7:0]  mem [P_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Payload storage; contents need no reset since pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; flush discards anything left from an earlier transaction
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/eeprom_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_ctrl
// Description : Transaction-level EEPROM controller in front of the I2C byte
//               engine. Buffers write payload, issues engine operations,
//               splits reads into single-byte operations and enforces the
//               write-cycle gap after every write operation.
//               Build option EEPROM_PAGE_SPLIT_EN: split writes at EEPROM
//               page boundaries, one engine operation (plus gap) per page.
// Revision    : 1.0 - initial release
// ============================================================================
module eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter logic [6:0] P_DEVICE_ADDR    = DEF_DEVICE_ADDR,
    parameter int         P_BUF_DEPTH      = DEF_BUF_DEPTH,
    parameter int         P_PAGE_SIZE      = DEF_PAGE_SIZE,
    parameter int         P_WR_WAIT_CYCLES = DEF_WR_WAIT_CYCLES
) (
    input  wire     i_clk,
    input  wire     i_rst,
    eeprom_if.slave bus
);
    localparam int          CW       = $clog2(P_BUF_DEPTH) + 1;
    localparam logic [31:0] GAP_LAST = (P_WR_WAIT_CYCLES > 0) ? 32'(P_WR_WAIT_CYCLES - 1) : 32'd0;

    generate
        if ((P_PAGE_SIZE < 1) || ((P_PAGE_SIZE & (P_PAGE_SIZE - 1)) != 0)) begin : g_bad_page
            $error("P_PAGE_SIZE must be a power of two");
        end
        if ((P_BUF_DEPTH < 2) || ((P_BUF_DEPTH & (P_BUF_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("P_BUF_DEPTH must be a power of two");
        end
    endgenerate

    state_t        state, state_nx;
    logic [1:0]    op_type;
    logic [15:0]   op_addr;
    logic [7:0]    op_len;
    logic [7:0]    remaining;
    logic [31:0]   gap_cnt;
    logic [7:0]    chunk;
    logic [7:0]    len_eff;
    logic          accept, type_ok, push, pop, issue;
    logic [7:0]    buf_dout;
    logic          buf_empty, buf_full;
    logic [CW-1:0] buf_count;
    logic [7:0]    write_data, rdata;
    logic          rvalid, rlast, done;

    assign accept  = (state == S_IDLE) && bus.i_user_valid;
    assign type_ok = (bus.i_user_type == TYPE_W) || (bus.i_user_type == TYPE_R);
    assign bus.o_user_wready = (state == S_LOAD) && !buf_full && (32'(buf_count) < 32'(op_len));
    assign push  = bus.o_user_wready && bus.i_user_wvalid;
    assign pop   = bus.i_write_req && !buf_empty;
    assign issue = (state == S_ISSUE);

    eeprom_wbuf #(.P_DEPTH(P_BUF_DEPTH)) u_wbuf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .flush (accept),
        .push  (push),
        .din   (bus.i_user_wdata),
        .pop   (pop),
        .dout  (buf_dout),
        .empty (buf_empty),
        .full  (buf_full),
        .count (buf_count)
    );

    // Write lengths beyond the buffer are clipped so LOAD can always finish
    always_comb begin
        len_eff = bus.i_user_len;
        if ((bus.i_user_type == TYPE_W) && (32'(bus.i_user_len) > P_BUF_DEPTH)) begin
            len_eff = 8'(P_BUF_DEPTH);
        end
    end

`ifdef EEPROM_PAGE_SPLIT_EN
    logic [15:0] page_room;
    assign page_room = 16'(P_PAGE_SIZE) - (op_addr & 16'(P_PAGE_SIZE - 1));
`endif

    // Size of the operation at op_addr; stable from ISSUE through BUSY
    always_comb begin
        chunk = remaining;
        if (op_type == TYPE_R) begin
            chunk = 8'd1;
        end
`ifdef EEPROM_PAGE_SPLIT_EN
        else if ({8'd0, remaining} > page_room) begin
            chunk = page_room[7:0];
        end
`endif
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; LOAD looks ahead so ISSUE follows the last byte at once
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if ((bus.i_user_len == 8'd0) || !type_ok) state_nx = S_DONE;
                    else if (bus.i_user_type == TYPE_W)       state_nx = S_LOAD;
                    else                                      state_nx = S_ISSUE;
                end
            end
            S_LOAD: begin
                if (push && (32'(buf_count) + 32'd1 == 32'(op_len))) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.i_operation_ready) state_nx = S_BUSY;
            end
            S_BUSY: begin
                if (bus.i_operation_ready) begin
                    if (op_type == TYPE_W)      state_nx = S_GAP;
                    else if (remaining == chunk) state_nx = S_DONE;
                    else                         state_nx = S_ISSUE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = (remaining == 8'd0) ? S_DONE : S_ISSUE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Transaction context: captured on acceptance, advanced per finished chunk
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_type   <= 2'd0;
            op_addr   <= 16'd0;
            op_len    <= 8'd0;
            remaining <= 8'd0;
            gap_cnt   <= 32'd0;
        end else if (accept) begin
            op_type   <= bus.i_user_type;
            op_addr   <= bus.i_user_addr;
            op_len    <= len_eff;
            remaining <= len_eff;
        end else if ((state == S_BUSY) && bus.i_operation_ready) begin
            op_addr   <= op_addr + 16'(chunk);
            remaining <= remaining - chunk;
            gap_cnt   <= 32'd0;
        end else if (state == S_GAP) begin
            gap_cnt   <= gap_cnt + 32'd1;
        end
    end

    // Write byte hold register, read byte return path and done pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            write_data <= 8'd0;
            rdata      <= 8'd0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (pop) write_data <= buf_dout;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if ((state == S_BUSY) && (op_type == TYPE_R) && bus.i_read_valid) begin
                rdata  <= bus.i_read_data;
                rvalid <= 1'b1;
                rlast  <= (remaining == 8'd1);
            end
            done <= (state == S_DONE);
        end
    end

    assign bus.o_user_ready       = (state == S_IDLE);
    assign bus.o_user_rdata       = rdata;
    assign bus.o_user_rvalid      = rvalid;
    assign bus.o_user_rlast       = rlast;
    assign bus.o_user_done        = done;
    assign bus.o_write_data       = write_data;
    assign bus.o_operation_valid  = issue;
    assign bus.o_operation_device = issue ? P_DEVICE_ADDR : 7'd0;
    assign bus.o_operation_addr   = issue ? op_addr : 16'd0;
    assign bus.o_operation_len    = issue ? chunk : 8'd0;
    assign bus.o_operation_type   = issue ? op_type : 2'd0;
endmodule
`default_nettype wire

// File: tb/tb_eeprom_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eeprom_ctrl
// Description : Scoreboard bench for eeprom_ctrl with a behavioural engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eeprom_ctrl;
    import eeprom_pkg::*;

    localparam int WAIT = 20;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  typ;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eeprom_if bus();

    eeprom_ctrl #(
        .P_DEVICE_ADDR    (7'h50),
        .P_BUF_DEPTH      (64),
        .P_PAGE_SIZE      (16),
        .P_WR_WAIT_CYCLES (WAIT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    op_t        exp_op_q[$];
    logic [7:0] exp_wd_q[$];
    logic [8:0] exp_rd_q[$];
    int         exp_done_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] pl [64];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ref_cyc = 0;
    int ops_seen = 0;
    int stall_next = 0;
    bit writes_off = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.o_user_ready, bus.o_user_wready, bus.o_user_rvalid, bus.o_user_rlast,
                    bus.o_user_done, bus.o_operation_valid, bus.o_operation_device,
                    bus.o_operation_addr, bus.o_operation_len, bus.o_operation_type,
                    bus.o_user_rdata, bus.o_write_data});
    endfunction

    localparam logic [63:0] RESET_VEC = 64'(1) << 54;

    // Scoreboard monitor: compares every DUT output event against the queues
    initial begin : monitor
        bit prev_req = 1'b0;
        op_t e;
        logic [8:0] er;
        int ed;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.o_operation_valid) begin
                    if (exp_op_q.size() == 0) begin
                        if (bus.i_operation_ready) unexpected("op_unexpected", 64'(bus.o_operation_addr));
                    end else begin
                        e = exp_op_q[0];
                        chk("op_fields",
                            64'({bus.o_operation_device, bus.o_operation_addr, bus.o_operation_len, bus.o_operation_type}),
                            64'({7'h50, e.addr, e.len, e.typ}));
                        if (bus.i_operation_ready) begin
                            void'(exp_op_q.pop_front());
                            ops_seen++;
                        end
                    end
                end
                if (prev_req) begin
                    if (exp_wd_q.size() == 0) unexpected("write_data_unexpected", 64'(bus.o_write_data));
                    else chk("write_data", 64'(bus.o_write_data), 64'(exp_wd_q.pop_front()));
                end
                prev_req = bus.i_write_req;
                if (bus.o_user_rvalid) begin
                    if (exp_rd_q.size() == 0) unexpected("read_unexpected", 64'(bus.o_user_rdata));
                    else begin
                        er = exp_rd_q.pop_front();
                        chk("read_data_last", 64'({bus.o_user_rlast, bus.o_user_rdata}), 64'(er));
                    end
                end
                if (bus.o_user_done) begin
                    if (exp_done_q.size() == 0) unexpected("done_unexpected", 64'(cyc));
                    else begin
                        ed = exp_done_q.pop_front();
                        chk("done_latency", 64'(cyc - ref_cyc), 64'(ed));
                    end
                end
            end
        end
    end

    // Behavioural I2C engine: handshake, byte requests / returns, ready return
    initial begin : engine
        int n;
        logic [1:0] t;
        int stall_left;
        stall_left = 0;
        bus.i_operation_ready = 1'b1;
        bus.i_write_req       = 1'b0;
        bus.i_read_valid      = 1'b0;
        bus.i_read_data       = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.o_operation_valid && !bus.i_operation_ready) begin
                stall_left--;
                if (stall_left <= 0) begin
                    @(posedge clk); #1;
                    bus.i_operation_ready = 1'b1;
                end
            end else if (bus.o_operation_valid && !rst) begin
                t = bus.o_operation_type;
                n = int'(bus.o_operation_len);
                @(posedge clk); #1;
                bus.i_operation_ready = 1'b0;
                if (t == TYPE_W) begin
                    if (writes_off) begin
                        repeat (3) @(posedge clk);
                    end else begin
                        for (int i = 0; i < n; i++) begin
                            bus.i_write_req = 1'b1;
                            @(posedge clk); #1;
                            bus.i_write_req = 1'b0;
                            @(posedge clk); #1;
                        end
                    end
                end else begin
                    @(posedge clk); #1;
                    bus.i_read_valid = 1'b1;
                    bus.i_read_data  = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
                    @(posedge clk); #1;
                    bus.i_read_valid = 1'b0;
                end
                @(posedge clk); #1;
                bus.i_operation_ready = 1'b1;
                ref_cyc = cyc;
            end else if (stall_next > 0) begin
                @(posedge clk); #1;
                bus.i_operation_ready = 1'b0;
                stall_left = stall_next;
                stall_next = 0;
            end
        end
    end

    task automatic do_req(input logic [1:0] t, input logic [15:0] a, input logic [7:0] l);
        int k;
        @(posedge clk); #1;
        bus.i_user_type  = t;
        bus.i_user_addr  = a;
        bus.i_user_len   = l;
        bus.i_user_valid = 1'b1;
        @(negedge clk);
        k = 0;
        while (!bus.o_user_ready && k < 100) begin @(negedge clk); k++; end
        if (!bus.o_user_ready) unexpected("accept_timeout", 64'(k));
        ref_cyc = cyc;
        @(posedge clk); #1;
        bus.i_user_valid = 1'b0;
    endtask

    task automatic send_payload(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.i_user_wdata  = pl[i];
            bus.i_user_wvalid = 1'b1;
            @(negedge clk);
            k = 0;
            while (!bus.o_user_wready && k < 100) begin @(negedge clk); k++; end
            if (!bus.o_user_wready) unexpected("wready_timeout", 64'(i));
        end
        @(posedge clk); #1;
        bus.i_user_wvalid = 1'b0;
    endtask

    task automatic finish_txn(input string name);
        int k;
        k = 0;
        while (exp_done_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
        chk({name, "_done_pending"}, 64'(exp_done_q.size()), 64'd0);
        chk({name, "_ops_pending"},  64'(exp_op_q.size()),   64'd0);
        chk({name, "_wd_pending"},   64'(exp_wd_q.size()),   64'd0);
        chk({name, "_rd_pending"},   64'(exp_rd_q.size()),   64'd0);
        repeat (3) @(posedge clk);
    endtask

    function automatic op_t mk(input logic [15:0] a, input logic [7:0] l, input logic [1:0] t);
        op_t o;
        o.addr = a; o.len = l; o.typ = t;
        return o;
    endfunction

    // Directed stimulus
    initial begin : main
        int k;
        bus.i_user_type = 2'd0; bus.i_user_addr = 16'd0; bus.i_user_len = 8'd0;
        bus.i_user_valid = 1'b0; bus.i_user_wdata = 8'd0; bus.i_user_wvalid = 1'b0;
        #2;
        chk("reset_outputs", out_vec(), RESET_VEC);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", out_vec(), RESET_VEC);

        // Write 4 bytes at 0x0010
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        exp_op_q.push_back(mk(16'h0010, 8'd4, TYPE_W));
        for (int i = 0; i < 4; i++) exp_wd_q.push_back(pl[i]);
        exp_done_q.push_back(WAIT + 2);
        do_req(TYPE_W, 16'h0010, 8'd4);
        send_payload(4);
        finish_txn("write4");

        // Read 3 bytes across the address wrap
        resp_q = '{8'hAA, 8'hBB, 8'hCC};
        exp_op_q.push_back(mk(16'hFFFE, 8'd1, TYPE_R));
        exp_op_q.push_back(mk(16'hFFFF, 8'd1, TYPE_R));
        exp_op_q.push_back(mk(16'h0000, 8'd1, TYPE_R));
        exp_rd_q.push_back({1'b0, 8'hAA});
        exp_rd_q.push_back({1'b0, 8'hBB});
        exp_rd_q.push_back({1'b1, 8'hCC});
        exp_done_q.push_back(2);
        do_req(TYPE_R, 16'hFFFE, 8'd3);
        finish_txn("read3_wrap");

        // Write 8 bytes at 0x001C, crossing a 16-byte page
        for (int i = 0; i < 8; i++) begin pl[i] = 8'(i + 1); exp_wd_q.push_back(8'(i + 1)); end
`ifdef EEPROM_PAGE_SPLIT_EN
        exp_op_q.push_back(mk(16'h001C, 8'd4, TYPE_W));
        exp_op_q.push_back(mk(16'h0020, 8'd4, TYPE_W));
`else
        exp_op_q.push_back(mk(16'h001C, 8'd8, TYPE_W));
`endif
        exp_done_q.push_back(WAIT + 2);
        do_req(TYPE_W, 16'h001C, 8'd8);
        send_payload(8);
        finish_txn("write8_page");

        // Zero length and invalid types: no engine op, done two cycles later
        exp_done_q.push_back(2);
        do_req(TYPE_W, 16'h0100, 8'd0);
        finish_txn("len0");
        exp_done_q.push_back(2);
        do_req(2'd3, 16'h0100, 8'd5);
        finish_txn("type3");
        exp_done_q.push_back(2);
        do_req(2'd0, 16'h0100, 8'd1);
        finish_txn("type0");

        // Engine stalls ready for 5 cycles during ISSUE
        stall_next = 5;
        repeat (3) @(posedge clk);
        resp_q = '{8'h5E, 8'h6F};
        exp_op_q.push_back(mk(16'h0040, 8'd1, TYPE_R));
        exp_op_q.push_back(mk(16'h0041, 8'd1, TYPE_R));
        exp_rd_q.push_back({1'b0, 8'h5E});
        exp_rd_q.push_back({1'b1, 8'h6F});
        exp_done_q.push_back(2);
        do_req(TYPE_R, 16'h0040, 8'd2);
        finish_txn("stall_read");

        // Oversize write is clipped to the buffer depth
        for (int i = 0; i < 64; i++) begin pl[i] = 8'(3 * i + 7); exp_wd_q.push_back(8'(3 * i + 7)); end
`ifdef EEPROM_PAGE_SPLIT_EN
        for (int i = 0; i < 4; i++) exp_op_q.push_back(mk(16'(16'h0200 + 16 * i), 8'd16, TYPE_W));
`else
        exp_op_q.push_back(mk(16'h0200, 8'd64, TYPE_W));
`endif
        exp_done_q.push_back(WAIT + 2);
        do_req(TYPE_W, 16'h0200, 8'd70);
        send_payload(64);
        finish_txn("write_clip");

        // Reset while the engine is busy with a write
        writes_off = 1'b1;
        for (int i = 0; i < 8; i++) pl[i] = 8'(8'hE0 + i);
`ifdef EEPROM_PAGE_SPLIT_EN
        exp_op_q.push_back(mk(16'h003C, 8'd4, TYPE_W));
`else
        exp_op_q.push_back(mk(16'h003C, 8'd8, TYPE_W));
`endif
        k = ops_seen;
        do_req(TYPE_W, 16'h003C, 8'd8);
        send_payload(8);
        while (ops_seen == k && cyc < 50000) @(negedge clk);
        chk("reset_test_op_issued", 64'(ops_seen - k), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("midreset_outputs", out_vec(), RESET_VEC);
        exp_op_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        k = 0;
        while (!bus.i_operation_ready && k < 100) begin @(negedge clk); k++; end
        writes_off = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", out_vec(), RESET_VEC);

        // Next request proceeds from an empty buffer
        pl[0] = 8'h5A; pl[1] = 8'hA5;
        exp_op_q.push_back(mk(16'h0100, 8'd2, TYPE_W));
        exp_wd_q.push_back(8'h5A);
        exp_wd_q.push_back(8'hA5);
        exp_done_q.push_back(WAIT + 2);
        do_req(TYPE_W, 16'h0100, 8'd2);
        send_payload(2);
        finish_txn("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
